// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and counter width.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

    localparam int LATENCY_BITS = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the controller (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int NBITS = 8
);
    logic             MemRead;
    logic             MemWrite;
    logic [NBITS-1:0] address;
    logic [NBITS-1:0] wdata;
    logic [NBITS-1:0] rdata;
    logic             busy;

    modport master (
        output MemRead, MemWrite, address, wdata,
        input  rdata, busy
    );

    modport slave (
        input  MemRead, MemWrite, address, wdata,
        output rdata, busy
    );
endinterface

// File: rtl/dmem_responder_mem_array.sv
// Storage array: synchronous write, asynchronous read, synchronous clear of every word on reset.
module mem_array #(
    parameter int NBITS  = 8,
    parameter int NWORDS = 32,
    localparam int IW    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [NBITS-1:0] wdat,
    input  logic [IW-1:0]    raddr,
    output logic [NBITS-1:0] rdat
);
    logic [NBITS-1:0] mem [NWORDS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stalls the initiator with busy for LATENCY cycles per access, then
// completes in a one-cycle DONE state. LATENCY == 0 removes the FSM and reads combinationally.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NWORDS  = 32,
    parameter int LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [IW-1:0]    idx;
    logic             we;
    logic [IW-1:0]    waddr;
    logic [IW-1:0]    raddr;
    logic [NBITS-1:0] wdat;
    logic [NBITS-1:0] rdat;

    assign idx = bus.address[IW-1:0];

    mem_array #(
        .NBITS  (NBITS),
        .NWORDS (NWORDS)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdat  (wdat),
        .raddr (raddr),
        .rdat  (rdat)
    );

    generate
        if (NBITS > IW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.address[NBITS-1:IW];
        end

        if (LATENCY == 0) begin : g_bypass
            logic unused_rd;
            assign unused_rd = bus.MemRead;

            assign we        = bus.MemWrite;
            assign waddr     = idx;
            assign wdat      = bus.wdata;
            assign raddr     = idx;
            assign bus.rdata = rdat;
            assign bus.busy  = 1'b0;
        end else begin : g_fsm
            localparam logic [LATENCY_BITS-1:0] CNT_LOAD = LATENCY_BITS'(LATENCY - 1);

            mem_state_t              state;
            logic [LATENCY_BITS-1:0] cnt;
            logic [IW-1:0]           lat_idx;
            logic [NBITS-1:0]        lat_wdata;
            logic                    lat_write;
            logic [NBITS-1:0]        rdata_q;

            logic req;
            logic start_done;
            logic finish;
            logic fin_write;

            assign req = bus.MemRead | bus.MemWrite;

            // With LATENCY == 1 the access completes straight from IDLE using the live inputs;
            // otherwise it completes from WAIT using the latched copies.
            assign start_done = (state == IDLE) && req && (CNT_LOAD == '0);
            assign finish     = start_done ||
                                ((state == WAIT) && (cnt <= LATENCY_BITS'(1)));
            assign fin_write  = start_done ? bus.MemWrite : lat_write;

            assign we    = finish && fin_write;
            assign waddr = start_done ? idx : lat_idx;
            assign raddr = waddr;
            assign wdat  = start_done ? bus.wdata : lat_wdata;

            assign bus.busy  = ((state == IDLE) && req) || (state == WAIT);
            assign bus.rdata = rdata_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    state     <= IDLE;
                    cnt       <= '0;
                    lat_idx   <= '0;
                    lat_wdata <= '0;
                    lat_write <= 1'b0;
                    rdata_q   <= '0;
                end else begin
                    if (finish && !fin_write) begin
                        rdata_q <= rdat;
                    end
                    case (state)
                        IDLE: begin
                            if (req) begin
                                lat_idx   <= idx;
                                lat_wdata <= bus.wdata;
                                lat_write <= bus.MemWrite;
                                cnt       <= CNT_LOAD;
                                state     <= (CNT_LOAD == '0) ? DONE : WAIT;
                            end
                        end
                        WAIT: begin
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                            end
                            if (finish) begin
                                state <= DONE;
                            end
                        end
                        DONE:    state <= IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_dmem_responder.sv
// Drives one stimulus stream into responders built with LATENCY 0/1/2/4 and checks the selected
// one every cycle against a transaction-level model of the memory and rdata register.
module tb_dmem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] address;
    logic [7:0] wdata;

    always #5 clk = ~clk;

    dmem_responder_if #(.NBITS(8)) if_l0 ();
    dmem_responder_if #(.NBITS(8)) if_l1 ();
    dmem_responder_if #(.NBITS(8)) if_l2 ();
    dmem_responder_if #(.NBITS(8)) if_l4 ();

    assign if_l0.MemRead = mem_read;  assign if_l0.MemWrite = mem_write;
    assign if_l0.address = address;   assign if_l0.wdata    = wdata;
    assign if_l1.MemRead = mem_read;  assign if_l1.MemWrite = mem_write;
    assign if_l1.address = address;   assign if_l1.wdata    = wdata;
    assign if_l2.MemRead = mem_read;  assign if_l2.MemWrite = mem_write;
    assign if_l2.address = address;   assign if_l2.wdata    = wdata;
    assign if_l4.MemRead = mem_read;  assign if_l4.MemWrite = mem_write;
    assign if_l4.address = address;   assign if_l4.wdata    = wdata;

    dmem_responder #(.NBITS(8), .NWORDS(32), .LATENCY(0)) u_l0 (.clock(clk), .reset(reset), .bus(if_l0));
    dmem_responder #(.NBITS(8), .NWORDS(32), .LATENCY(1)) u_l1 (.clock(clk), .reset(reset), .bus(if_l1));
    dmem_responder #(.NBITS(8), .NWORDS(32), .LATENCY(2)) u_l2 (.clock(clk), .reset(reset), .bus(if_l2));
    dmem_responder #(.NBITS(8), .NWORDS(32), .LATENCY(4)) u_l4 (.clock(clk), .reset(reset), .bus(if_l4));

    logic       busy_v  [4];
    logic [7:0] rdata_v [4];
    assign busy_v[0] = if_l0.busy;  assign rdata_v[0] = if_l0.rdata;
    assign busy_v[1] = if_l1.busy;  assign rdata_v[1] = if_l1.rdata;
    assign busy_v[2] = if_l2.busy;  assign rdata_v[2] = if_l2.rdata;
    assign busy_v[3] = if_l4.busy;  assign rdata_v[3] = if_l4.rdata;

    // Model state
    int         sel = 0;
    int         lat = 0;
    logic [7:0] m_mem [32];
    logic [7:0] m_rdata;
    logic       exp_busy  = 1'b0;
    logic [7:0] exp_rdata = 8'h00;
    bit         chk_busy  = 1'b0;
    bit         chk_rdata = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (LATENCY=%0d t=%0t): got %h, expected %h", name, lat, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_busy)  check("busy",  {7'b0, busy_v[sel]}, {7'b0, exp_busy});
        if (chk_rdata) check("rdata", rdata_v[sel], exp_rdata);
    end

    function automatic int lat_of(input int s);
        case (s)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_dut(input int s);
        chk_busy  = 1'b0;
        chk_rdata = 1'b0;
        sel = s;
        lat = lat_of(s);
    endtask

    task automatic do_reset(input int n);
        chk_busy  = 1'b0;
        chk_rdata = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reset     = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        m_rdata = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            address   = 8'($urandom);
            wdata     = 8'($urandom);
            exp_busy  = 1'b0;
            chk_busy  = 1'b1;
            exp_rdata = m_rdata;
            chk_rdata = (lat != 0);
            step();
        end
    endtask

    // One complete access as the initiator sees it; mess scrambles inputs after acceptance.
    task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input bit mess);
        mem_read  = rd;
        mem_write = wr;
        address   = a;
        wdata     = d;
        chk_busy  = 1'b1;
        exp_busy  = 1'b0;
        if (lat == 0) begin
            exp_rdata = m_mem[a[4:0]];
            chk_rdata = rd && !wr;
            step();
            if (wr) m_mem[a[4:0]] = d;
        end else begin
            chk_rdata = 1'b1;
            exp_rdata = m_rdata;
            exp_busy  = 1'b1;
            for (int i = 0; i < lat; i++) begin
                if (i > 0 && mess) begin
                    mem_read  = 1'($urandom);
                    mem_write = 1'($urandom);
                    address   = 8'($urandom);
                    wdata     = 8'($urandom);
                end
                step();
            end
            if (wr) m_mem[a[4:0]] = d;
            else    m_rdata = m_mem[a[4:0]];
            exp_busy  = 1'b0;
            exp_rdata = m_rdata;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        address   = 8'h00;
        wdata     = 8'h00;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        m_rdata = 8'h00;
        step();

        // LATENCY 2: reset, clear, write/read, both-high, alias
        sel_dut(2);
        do_reset(2);
        #1;
        check("reset_busy",  {7'b0, busy_v[sel]}, 8'h00);
        check("reset_rdata", rdata_v[sel], 8'h00);
        for (int i = 0; i < 32; i++) begin
            access(1'b1, 1'b0, 8'(i), 8'($urandom), 1'b0);
            check("clear_word", rdata_v[sel], 8'h00);
        end
        access(1'b0, 1'b1, 8'h03, 8'hA5, 1'b0);
        access(1'b1, 1'b0, 8'h03, 8'h00, 1'b0);
        check("read_A5", rdata_v[sel], 8'hA5);
        access(1'b1, 1'b1, 8'h05, 8'h3C, 1'b0);
        check("both_keeps_rdata", rdata_v[sel], 8'hA5);
        access(1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
        check("read_3C", rdata_v[sel], 8'h3C);
        access(1'b0, 1'b1, 8'h21, 8'h11, 1'b0);
        access(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
        check("alias_11", rdata_v[sel], 8'h11);
        idle(2);

        // LATENCY 4: reset in the second busy cycle aborts the write
        sel_dut(3);
        do_reset(2);
        access(1'b0, 1'b1, 8'h07, 8'h5E, 1'b0);
        mem_read  = 1'b0;
        mem_write = 1'b1;
        address   = 8'h07;
        wdata     = 8'hFF;
        chk_busy  = 1'b1;
        exp_busy  = 1'b1;
        chk_rdata = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        mem_write = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        m_rdata   = 8'h00;
        exp_busy  = 1'b0;
        exp_rdata = 8'h00;
        chk_rdata = 1'b1;
        #1;
        check("abort_busy", {7'b0, busy_v[sel]}, 8'h00);
        step();
        access(1'b1, 1'b0, 8'h07, 8'h00, 1'b0);
        check("abort_read", rdata_v[sel], 8'h00);

        // LATENCY 0: combinational read sees the previous cycle's write
        sel_dut(0);
        do_reset(2);
        access(1'b0, 1'b1, 8'h02, 8'h5A, 1'b0);
        mem_read  = 1'b1;
        mem_write = 1'b0;
        address   = 8'h02;
        exp_busy  = 1'b0;
        exp_rdata = m_mem[2];
        chk_busy  = 1'b1;
        chk_rdata = 1'b1;
        #1;
        check("zero_lat_rdata", rdata_v[sel], 8'h5A);
        check("zero_lat_busy",  {7'b0, busy_v[sel]}, 8'h00);
        step();

        // Randomized traffic on every latency
        for (int s = 0; s < 4; s++) begin
            sel_dut(s);
            do_reset(1 + $urandom_range(0, 2));
            for (int k = 0; k < 150; k++) begin
                int r;
                r = $urandom_range(0, 19);
                if (r == 0) begin
                    do_reset(1);
                end else if (r < 5) begin
                    idle(1 + $urandom_range(0, 1));
                end else begin
                    access(r < 11 || r == 19, r >= 11, 8'($urandom), 8'($urandom),
                           1'($urandom));
                end
            end
            idle(1);
        end

        chk_busy  = 1'b0;
        chk_rdata = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V controller. It serves `MemRead`/`MemWrite` requests from the controller/datapath and holds the initiator off with `busy` for a programmable number of wait states. It sits in the top level beside `inst`, on the controller's load/store interface.

## Interface
Parameters:
- `NBITS`, 8: address and data width.
- `NWORDS`, 32: number of storage words; index = `address[$clog2(NWORDS)-1:0]`; upper address bits are ignored.
- `LATENCY`, 2: number of busy cycles per access. Legal range 0..15.

Ports:
- `clock` input, 1: single clock; all state changes on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `MemRead` input, 1: read request. Held by the initiator until it sees `busy` low.
- `MemWrite` input, 1: write request. Same rules as `MemRead`.
- `address` input, NBITS: byte/word address from the ALU.
- `wdata` input, NBITS: write data (RS2 value).
- `rdata` output, NBITS: read data.
- `busy` output, 1: access in progress; the initiator stalls while it is high.

## Operation
- Request: `req = MemRead | MemWrite`. If both are high, the access is a write.
- States:
  - `IDLE`: no access pending.
  - `WAIT`: access latched, counting down.
  - `DONE`: one-cycle completion.
- `IDLE` with `req`:
  - Latch `address`, `wdata`, `is_write`.
  - Load `cnt = LATENCY-1`.
  - Go to `DONE` if `cnt == 0`, else go to `WAIT`.
- `WAIT`: `cnt` decrements each cycle. When `cnt == 0`, go to `DONE`.
  - On that edge a write commits to the array using the latched index and data.
  - On that edge a read loads `rdata <= mem[latched index]`.
- `DONE`: `busy = 0` for exactly one cycle; always go to `IDLE`. This guarantees a held request is not re-accepted as a new one.
- `busy` is combinational: `(state==IDLE && req) || state==WAIT`. With `LATENCY == 1` the transition is `IDLE` → `DONE` and `busy` is high only in the request cycle.
- `LATENCY == 0`: the FSM is bypassed.
  - `busy` is always 0.
  - `rdata = mem[address index]` combinationally.
  - A write commits on the request-cycle edge.
- `rdata` holds its value until the next completed read. Writes never change `rdata`.
- Inputs that change or drop during `WAIT` (a protocol violation) are ignored: the access completes with the latched values.
- Reset:
  - State goes to `IDLE`, `cnt = 0`, `rdata = 0`, and every memory word is cleared to 0.
  - `busy` is 0 in the cycle after reset, unless `req` is high in `IDLE`.
  - Reset during `WAIT` aborts the access; a pending write is discarded.

## Timing
- Access latency: a request presented in cycle t with `LATENCY = L ≥ 1`:
  - `busy` is high in cycles t..t+L-1.
  - `busy` is low and `rdata` is valid in cycle t+L (`DONE`).
  - The controller advances at the end of cycle t+L.
- Throughput: one access per L+1 cycles. Idle-to-request needs no setup cycle.
- Write visibility: data written at the `WAIT`→`DONE` edge is visible to a read issued in the following cycle.
- Counter width: 4 bits, unsigned. `cnt` never wraps: the decrement only happens when `cnt > 0`.

## Structure
- Shared package (`mem_pkg`):
  - `typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t`.
  - `LATENCY_BITS = 4`.
- Sub-module `mem_array #(NBITS, NWORDS)`:
  - Synchronous-write, asynchronous-read storage with synchronous clear.
  - `dmem_responder` holds the FSM, counter, input latches and the `rdata` register.

## Test plan
- Reset check: assert `reset` for 2 cycles with `LATENCY=2` → `busy=0`, `rdata=0`, every `mem` word is 0.
- Write then read:
  - `LATENCY=2`, write `wdata=8'hA5` to `address=8'h03` → `busy` is high for exactly 2 cycles, then low 1 cycle.
  - Then read `address=8'h03` → `rdata=8'hA5` in the `DONE` cycle.
- Simultaneous read and write: `MemRead=MemWrite=1`, `wdata=8'h3C` to `address=8'h05`, with `rdata` previously `8'hA5`:
  - `rdata` stays `8'hA5`.
  - A subsequent read of `address=8'h05` returns `8'h3C`.
- Address alias: write `8'h11` to `address=8'h21` with `NWORDS=32`, then read `address=8'h01` → `rdata=8'h11`.
- Reset mid-access: start a write of `8'hFF` to `address=8'h07` with `LATENCY=4`, assert `reset` in the second busy cycle:
  - `busy=0` the next cycle.
  - A later read of `address=8'h07` returns `8'h00`.
- Zero latency: `LATENCY=0`, write `8'h5A` to `address=8'h02`, then in the next cycle set `MemRead=1` with `address=8'h02`:
  - `busy` stays 0 throughout.
  - `rdata=8'h5A` in that same cycle.
